ip_seek_controller: RTL

- Sequencer in front of the dekatron instruction-pointer counter: issues single step pulses and direction to the counter and hides its settling time behind a request/done handshake.
- Runs bracket-matching seeks: forward from '[' to the matching ']', and backward from ']' to the matching '['. It counts nesting depth from opcodes fetched at each IP position.
- Sits between the instruction decoder (requester) and the IP counter plus program ROM.

---
 rtl/ip_seek_controller_if.sv | 39 +++
 rtl/ip_seek_controller.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ip_seek_controller_if.sv
// ip_seek_controller_if: groups the decoder request/done handshake together with
// the step/direction/ready lines of the IP counter and the program ROM opcode.
// The seek_steps statistics signal exists only when IP_SEEK_STATS_EN is defined.
interface ip_seek_controller_if #(
    parameter int DEPTH_W = 4
);
    logic               request;
    logic [1:0]         cmd;
    logic               busy;
    logic               done;
    logic               error;
    logic               ip_step;
    logic               ip_reverse;
    logic               ip_ready;
    logic               ip_at_zero;
    logic [3:0]         insn;
    logic [DEPTH_W-1:0] depth;
`ifdef IP_SEEK_STATS_EN
    logic [15:0]        seek_steps;
`endif

    // Environment side: decoder issuing requests, IP counter and program ROM.
    modport master (
        output request, cmd, ip_ready, ip_at_zero, insn,
`ifdef IP_SEEK_STATS_EN
        input  seek_steps,
`endif
        input  busy, done, error, ip_step, ip_reverse, depth
    );

    // Controller side.
    modport slave (
        input  request, cmd, ip_ready, ip_at_zero, insn,
`ifdef IP_SEEK_STATS_EN
        output seek_steps,
`endif
        output busy, done, error, ip_step, ip_reverse, depth
    );
endinterface

// File: rtl/ip_seek_controller.sv
// ip_seek_controller: sequences single steps of the dekatron IP counter behind a
// request/done handshake and runs bracket-matching seeks in either direction,
// tracking nesting depth from the opcode fetched at each IP position.
// Optional feature: define IP_SEEK_STATS_EN to add the seek_steps step counter.
module ip_seek_controller #(
    parameter int         DEPTH_W  = 4,
    parameter int         ROM_LAT  = 1,
    parameter logic [3:0] OP_OPEN  = 4'h6,
    parameter logic [3:0] OP_CLOSE = 4'h7,
    parameter logic [3:0] OP_HALT  = 4'hF
) (
    input  logic                 clk,
    input  logic                 rst,
    ip_seek_controller_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_WAIT_RDY,
        S_FETCH,
        S_SCAN,
        S_FINISH
    } state_t;

    localparam logic [1:0]         CMD_NEXT   = 2'b00;
    localparam logic [1:0]         CMD_FWD    = 2'b01;
    localparam logic [1:0]         CMD_BACK   = 2'b10;
    localparam logic [1:0]         CMD_RSVD   = 2'b11;
    localparam logic [DEPTH_W-1:0] DEPTH_MAX  = {DEPTH_W{1'b1}};
    localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);
    localparam logic [2:0]         FETCH_LAST = 3'(ROM_LAT - 1);

    state_t             state;
    state_t             next_state;
    logic [1:0]         cmd_q;
    logic [DEPTH_W-1:0] depth_q;
    logic [DEPTH_W-1:0] depth_d;
    logic               error_q;
    logic               ip_reverse_q;
    logic [2:0]         fetch_cnt;
    logic               accept;
    logic               set_error;
    logic               deeper;
    logic               shallower;
    logic               halt_hit;

    // Classify the fetched opcode relative to the seek direction.
    always_comb begin
        deeper    = 1'b0;
        shallower = 1'b0;
        halt_hit  = 1'b0;
        if (cmd_q == CMD_FWD) begin
            deeper    = (bus.insn == OP_OPEN);
            shallower = (bus.insn == OP_CLOSE);
            halt_hit  = (bus.insn == OP_HALT);
        end else if (cmd_q == CMD_BACK) begin
            deeper    = (bus.insn == OP_CLOSE);
            shallower = (bus.insn == OP_OPEN);
        end
    end

    // Next-state, depth update and error-raising decisions.
    always_comb begin
        next_state = state;
        depth_d    = depth_q;
        accept     = 1'b0;
        set_error  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.request) begin
                    accept     = 1'b1;
                    next_state = S_SETUP;
                    depth_d    = (bus.cmd == CMD_FWD || bus.cmd == CMD_BACK) ? DEPTH_ONE : '0;
                end
            end
            S_SETUP: begin
                if (cmd_q == CMD_RSVD || (cmd_q == CMD_BACK && bus.ip_at_zero)) begin
                    set_error  = 1'b1;
                    next_state = S_FINISH;
                end else begin
                    next_state = S_PULSE;
                end
            end
            S_PULSE: begin
                next_state = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                if (bus.ip_ready) begin
                    next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                if (fetch_cnt == FETCH_LAST) begin
                    next_state = S_SCAN;
                end
            end
            S_SCAN: begin
                if (cmd_q == CMD_NEXT) begin
                    next_state = S_FINISH;
                end else if (halt_hit) begin
                    set_error  = 1'b1;
                    next_state = S_FINISH;
                end else if (deeper) begin
                    if (depth_q == DEPTH_MAX) begin
                        set_error  = 1'b1;
                        next_state = S_FINISH;
                    end else begin
                        depth_d    = depth_q + DEPTH_ONE;
                        next_state = S_SETUP;
                    end
                end else begin
                    if (shallower) begin
                        depth_d = depth_q - DEPTH_ONE;
                    end
                    next_state = (depth_d == '0) ? S_FINISH : S_SETUP;
                end
            end
            S_FINISH: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Latched command, direction, depth, sticky error and ROM latency counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q        <= CMD_NEXT;
            ip_reverse_q <= 1'b0;
            depth_q      <= '0;
            error_q      <= 1'b0;
            fetch_cnt    <= '0;
        end else begin
            depth_q   <= depth_d;
            fetch_cnt <= (state == S_FETCH) ? fetch_cnt + 3'd1 : 3'd0;
            if (accept) begin
                cmd_q        <= bus.cmd;
                ip_reverse_q <= (bus.cmd == CMD_BACK);
                error_q      <= 1'b0;
            end else if (set_error) begin
                error_q <= 1'b1;
            end
        end
    end

`ifdef IP_SEEK_STATS_EN
    logic [15:0] seek_steps_q;

    // Saturating count of step pulses issued since the last accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            seek_steps_q <= '0;
        end else if (accept) begin
            seek_steps_q <= '0;
        end else if (state == S_PULSE && seek_steps_q != 16'hFFFF) begin
            seek_steps_q <= seek_steps_q + 16'd1;
        end
    end

    assign bus.seek_steps = seek_steps_q;
`endif

    assign bus.busy       = (state != S_IDLE);
    assign bus.done       = (state == S_FINISH);
    assign bus.ip_step    = (state == S_PULSE);
    assign bus.ip_reverse = ip_reverse_q;
    assign bus.error      = error_q;
    assign bus.depth      = depth_q;
endmodule
